// File: rtl/write_arbiter.sv
// Round-robin write arbiter: picks one lane request, captures its address and
// payload, and drives the transfer on the downstream valid/ready port.
//
// state | meaning
// IDLE  | no transfer in flight; arbitrates among requesting lanes
// SEND  | captured transfer presented on wr_*; waits for wr_ready
module write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 1024,
  parameter int ADDR_WIDTH = 10,
  parameter int LANE_W     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            arbiter_write_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] router_dst_addr_recv,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_arbiter_recv,
  output logic [NUM_REQ-1:0]            arbiter_write_gnt,
  output logic                          wr_valid,
  input  logic                          wr_ready,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [LANE_W-1:0]             wr_lane,
  output logic                          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;

  logic [1:0]            state_q, state_d;
  logic [LANE_W-1:0]     last_gnt_q, last_gnt_d;
  logic [NUM_REQ-1:0]    gnt_q, gnt_d;
  logic                  valid_q, valid_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [LANE_W-1:0]     lane_q, lane_d;

  logic                  win_found;
  logic [LANE_W-1:0]     win_idx;
  logic [LANE_W-1:0]     scan_idx;

  // Scan starts one past the last winner; NUM_REQ is a power of two so the
  // LANE_W-bit sum wraps naturally.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan_idx = last_gnt_q + LANE_W'(k);
      if (!win_found && arbiter_write_req[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = '0;
    valid_d    = valid_q;
    addr_d     = addr_q;
    data_d     = data_q;
    lane_d     = lane_q;
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        lane_d  = '0;
        if (win_found) begin
          state_d    = SEND;
          last_gnt_d = win_idx;
          gnt_d      = NUM_REQ'(1) << win_idx;
          valid_d    = 1'b1;
          addr_d     = router_dst_addr_recv[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          data_d     = data_arbiter_recv[win_idx*DATA_WIDTH +: DATA_WIDTH];
          lane_d     = win_idx;
        end
      end
      SEND: begin
        if (valid_q && wr_ready) begin
          state_d = IDLE;
          valid_d = 1'b0;
          addr_d  = '0;
          data_d  = '0;
          lane_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        lane_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_gnt_q <= LANE_W'(NUM_REQ - 1);
      gnt_q      <= '0;
      valid_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      lane_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      valid_q    <= valid_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      lane_q     <= lane_d;
    end
  end

  assign arbiter_write_gnt = gnt_q;
  assign wr_valid          = valid_q;
  assign wr_addr           = addr_q;
  assign wr_data           = data_q;
  assign wr_lane           = lane_q;
  assign busy              = (state_q == SEND);

endmodule

// File: doc/write_arbiter.md
# write_arbiter

Round-robin write arbiter for the 4-lane router. It shares one downstream write port between NUM_REQ lane-side write requesters, each of which presents a registered request with destination address and payload and holds it until granted. Per transfer, the arbiter selects one requester, captures its address and data into an output register, and returns a one-cycle grant pulse. It then drives the captured transfer on the downstream valid/ready port until the port accepts it.

## Interface
- NUM_REQ, 4, number of requesting lanes (power of two, ≥2)
- DATA_WIDTH, 1024, payload width
- ADDR_WIDTH, 10, router destination address width
- LANE_W, $clog2(NUM_REQ), lane index width (derived)

- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- arbiter_write_req  in  NUM_REQ  per-lane request; high = lane's addr/data valid
- router_dst_addr_recv  in  NUM_REQ*ADDR_WIDTH  lane i address at [i*ADDR_WIDTH +: ADDR_WIDTH]
- data_arbiter_recv  in  NUM_REQ*DATA_WIDTH  lane i payload at [i*DATA_WIDTH +: DATA_WIDTH]
- arbiter_write_gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
- wr_valid  out  1  downstream transfer valid
- wr_ready  in  1  downstream accepts when wr_valid & wr_ready
- wr_addr  out  ADDR_WIDTH  captured destination address
- wr_data  out  DATA_WIDTH  captured payload
- wr_lane  out  LANE_W  source lane of current transfer
- busy  out  1  high while state = SEND

## Operation
- States: IDLE, SEND. Reset → IDLE.
- Rotating priority pointer last_gnt (LANE_W bits), reset value NUM_REQ-1, so lane 0 has highest priority first.
- IDLE, no request: all outputs are 0 and the state stays IDLE.
- IDLE, any request bit high: the winner is the first set bit scanning last_gnt+1, last_gnt+2, … modulo NUM_REQ. At the clock edge:
  - wr_addr and wr_data are loaded from the winner's slice, and wr_lane is set to the winner.
  - wr_valid is set to 1, and arbiter_write_gnt[winner] is set to 1.
  - last_gnt is set to the winner, and the state moves to SEND.
- SEND: requests are ignored.
  - arbiter_write_gnt is 0 after its single cycle.
  - wr_valid, wr_addr, wr_data and wr_lane hold stable until wr_ready = 1.
  - On wr_valid & wr_ready: at the next edge wr_valid, wr_addr, wr_data and wr_lane clear to 0, and the state moves to IDLE.
- Requester contract: a granted requester drops its request on the edge after it sees the grant. The arbiter re-enters IDLE no earlier than that edge, so a stale request is never re-granted.
- Outputs are registered. Only the winner selection is combinational from arbiter_write_req and last_gnt.
- Reset mid-transfer: all outputs → 0, state → IDLE, last_gnt → NUM_REQ-1. An in-flight transfer is dropped.
- Illegal state encodings return to IDLE with outputs cleared.

## Timing
- All outputs reset to 0.
- Request high in IDLE at cycle t → at cycle t+1 the grant pulse, wr_valid, and the captured wr_addr, wr_data and wr_lane are all visible.
- wr_ready high at cycle t+1 → transfer completes at t+1 and wr_valid = 0 at t+2 (state IDLE).
- A new request seen in IDLE at t+2 is granted at t+3, so peak throughput is one transfer per 2 cycles.
- Backpressure: each cycle with wr_ready = 0 in SEND adds one cycle. The grant pulse width stays 1 cycle regardless.
- Simultaneous requests are resolved purely by rotation. Every continuously requesting lane is granted within NUM_REQ transfers (no starvation).
- Requests that rise during SEND are considered only on return to IDLE.

## Test plan
- Single lane: lane 2 requests with addr 0x155 and data pattern A, wr_ready = 1.
  - Next cycle: gnt = 4'b0100, wr_valid = 1, wr_addr = 0x155, wr_data = A, wr_lane = 2.
  - Following cycle: wr_valid = 0 and gnt = 0.
- After reset, all four lanes request continuously with distinct data and the requester contract applied.
  - Grants occur in order 0, 1, 2, 3, 0, with wr_lane and wr_addr matching each lane, every 2 cycles.
- Backpressure: lane 1 is granted, then wr_ready is held 0 for 5 cycles.
  - wr_valid, wr_addr and wr_data are stable for all 6 cycles and the grant stays a single pulse.
  - Lanes 0 and 3 request during the stall; after completion lane 3 is granted next (pointer = 1).
- Rotation fairness: last grant was lane 3, then lanes 0 and 3 request together.
  - Lane 0 wins; after completion lane 3 wins.
- Reset mid-transfer: rst_n is asserted while in SEND with wr_valid = 1.
  - All outputs are 0 immediately, without waiting for a clock.
  - After release with lanes 1 and 2 requesting, lane 1 is granted first.
- Idle hold: no requests for 10 cycles.
  - gnt, wr_valid and busy stay 0, and wr_addr and wr_data stay 0.
